// File: rtl/fp_div_pkg.sv
// Shared constants and state encoding for the sequential mantissa divider.
package fp_div_pkg;
    localparam int DEF_MANT_W = 23;
    localparam int DEF_Q_W    = DEF_MANT_W + 3;
    localparam int DEF_CNT_W  = $clog2(DEF_Q_W);

    typedef enum logic [1:0] {IDLE, INIT, LOAD, DIV} state_t;
endpackage

// File: rtl/fp_mant_div_dp.sv
// Restoring-division datapath: remainder, divisor, quotient shift register, sticky.
module fp_mant_div_dp #(
    parameter int MANT_W = 23,
    parameter int Q_W    = MANT_W + 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              loadOps,
    input  logic              shiftQ,
    input  logic              initQ,
    input  logic [MANT_W-1:0] A,
    input  logic [MANT_W-1:0] B,
    output logic [Q_W-1:0]    quotient,
    output logic              sticky
);
    logic [MANT_W+1:0] r;
    logic [MANT_W:0]   d;
    logic [Q_W-1:0]    q;
    logic [MANT_W+2:0] diff;
    logic              q_bit;
    logic [MANT_W+1:0] r_nxt;

    // One extra bit so the borrow shows up as the sign of the trial subtraction.
    assign diff  = {1'b0, r} - {2'b00, d};
    assign q_bit = ~diff[MANT_W+2];
    // R < 2*D keeps both shifted forms inside MANT_W+2 bits.
    assign r_nxt = q_bit ? {diff[MANT_W:0], 1'b0} : {r[MANT_W:0], 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r <= '0;
            d <= '0;
            q <= '0;
        end else begin
            if (loadOps) begin
                r <= {2'b01, A};
                d <= {1'b1, B};
            end else if (shiftQ) begin
                r <= r_nxt;
            end
            if (initQ)
                q <= '0;
            else if (shiftQ)
                q <= {q[Q_W-2:0], q_bit};
        end
    end

    assign quotient = q;
    assign sticky   = |r;
endmodule

// File: rtl/fp_mant_div_seq.sv
// Sequential mantissa divider: start/done handshake FSM and iteration counter around the datapath.
module fp_mant_div_seq
    import fp_div_pkg::*;
#(
    parameter  int MANT_W = DEF_MANT_W,
    localparam int Q_W    = MANT_W + 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              startDiv,
    input  logic [MANT_W-1:0] A,
    input  logic [MANT_W-1:0] B,
    output logic [Q_W-1:0]    quotient,
    output logic              sticky,
    output logic              doneDiv
);
    localparam int CNT_W = $clog2(Q_W);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             loadOps, shiftQ, initQ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (initQ)
                cnt <= '0;
            else if (shiftQ)
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        loadOps   = 1'b0;
        shiftQ    = 1'b0;
        initQ     = 1'b0;
        doneDiv   = 1'b0;
        case (state)
            IDLE: begin
                doneDiv = 1'b1;
                if (startDiv) state_nxt = INIT;
            end
            // Operation begins only once the initiator releases startDiv.
            INIT: begin
                initQ = 1'b1;
                if (!startDiv) state_nxt = LOAD;
            end
            LOAD: begin
                loadOps   = 1'b1;
                state_nxt = DIV;
            end
            DIV: begin
                shiftQ = 1'b1;
                if (cnt == CNT_W'(Q_W - 1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    fp_mant_div_dp #(.MANT_W(MANT_W), .Q_W(Q_W)) u_dp (
        .clk      (clk),
        .rst      (rst),
        .loadOps  (loadOps),
        .shiftQ   (shiftQ),
        .initQ    (initQ),
        .A        (A),
        .B        (B),
        .quotient (quotient),
        .sticky   (sticky)
    );
endmodule

// File: tb/tb_fp_mant_div_seq.sv
// Self-checking bench: directed and random mantissa divides against an arithmetic reference.
module tb_fp_mant_div_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        startDiv = 1'b0;
    logic [22:0] A = '0, B = '0;
    logic [25:0] quotient;
    logic        sticky, doneDiv;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    fp_mant_div_seq dut (
        .clk(clk), .rst(rst), .startDiv(startDiv), .A(A), .B(B),
        .quotient(quotient), .sticky(sticky), .doneDiv(doneDiv)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer quotient of {1,A}*2^25 / {1,B} and nonzero remainder.
    function automatic logic [63:0] ref_q(input logic [22:0] a, input logic [22:0] b);
        longint x = longint'({1'b1, a});
        longint y = longint'({1'b1, b});
        return 64'((x <<< 25) / y);
    endfunction

    function automatic logic ref_s(input logic [22:0] a, input logic [22:0] b);
        longint x = longint'({1'b1, a});
        longint y = longint'({1'b1, b});
        return ((x <<< 25) % y) != 0;
    endfunction

    // Inputs are driven and outputs sampled on the falling edge.
    // scramble: change A/B mid-divide; pulse: raise startDiv mid-divide.
    task automatic run_op(input string tag, input logic [22:0] a, input logic [22:0] b,
                          input int hold, input bit scramble, input bit pulse);
        int cyc = 0;
        bit inited = 1'b1;
        A = a; B = b;
        startDiv = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); @(negedge clk);
            if (doneDiv !== 1'b0) inited = 1'b0;
        end
        chk({tag, "_init_hold"}, 64'(inited), 64'd1);
        startDiv = 1'b0;
        while (cyc < 100) begin
            @(posedge clk); cyc++; @(negedge clk);
            if (scramble && cyc == 6) begin A = ~a; B = a ^ b; end
            if (pulse && cyc == 8) startDiv = 1'b1;
            if (pulse && cyc == 10) startDiv = 1'b0;
            if (doneDiv === 1'b1) break;
        end
        chk({tag, "_latency"}, 64'(cyc), 64'd28);
        chk({tag, "_quot"}, 64'(quotient), ref_q(a, b));
        chk({tag, "_sticky"}, 64'(sticky), 64'(ref_s(a, b)));
        // Result must hold while idle.
        @(posedge clk); @(negedge clk);
        chk({tag, "_hold"}, 64'(quotient), ref_q(a, b));
    endtask

    initial begin
        logic [22:0] ra, rb;
        #12;
        chk("rst_done", 64'(doneDiv), 64'd1);
        chk("rst_quot", 64'(quotient), 64'd0);
        chk("rst_sticky", 64'(sticky), 64'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        run_op("eq", 23'h0, 23'h0, 1, 0, 0);
        chk("eq_const", 64'(quotient), 64'h2000000);
        run_op("r15", 23'h400000, 23'h0, 1, 0, 0);
        chk("r15_const", 64'(quotient), 64'h3000000);
        run_op("inex", 23'h0, 23'h400000, 1, 0, 0);
        chk("inex_const", 64'(quotient), 64'h1555555);
        chk("inex_sticky_c", 64'(sticky), 64'd1);
        run_op("maxa", 23'h7FFFFF, 23'h0, 1, 0, 0);
        chk("maxa_const", 64'(quotient), 64'h3FFFFFC);
        run_op("maxb", 23'h0, 23'h7FFFFF, 1, 0, 0);
        chk("maxb_const", 64'(quotient), 64'h1000001);
        run_op("hold5", 23'h123456, 23'h654321, 5, 0, 0);
        run_op("scram", 23'h2AAAAA, 23'h155555, 2, 1, 0);
        run_op("pulse", 23'h0ABCDE, 23'h7EDCBA, 1, 0, 1);

        // Reset during the tenth DIV cycle.
        A = 23'h400000; B = 23'h0; startDiv = 1'b1;
        @(posedge clk); @(negedge clk);
        startDiv = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("mid_busy", 64'(doneDiv), 64'd0);
        rst = 1'b1; #1;
        chk("mid_rst_done", 64'(doneDiv), 64'd1);
        chk("mid_rst_quot", 64'(quotient), 64'd0);
        chk("mid_rst_sticky", 64'(sticky), 64'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        run_op("post_rst", 23'h400000, 23'h0, 1, 0, 0);
        chk("post_rst_const", 64'(quotient), 64'h3000000);

        for (int n = 0; n < 20; n++) begin
            ra = 23'($urandom);
            rb = 23'($urandom);
            run_op("rand", ra, rb, 1 + int'($urandom_range(0, 2)), 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fp_mant_div_seq.md
Name: fp_mant_div_seq

Overview:
- Sequential restoring divider for IEEE754 single-precision mantissas; the division-side counterpart of the team's shift-add mantissa multiplier.
- Prepends the hidden 1 to both fractions and produces a normalisable quotient plus a sticky bit. The FP divide path consumes these for exponent adjust and rounding.
- Uses the same start/done handshake as the multiplier, so the same top-level controller can drive either unit.

Parameters:
- MANT_W, 23, stored fraction width; operands are internally MANT_W+1 bits with the hidden 1.
- Derived constant, not overridable: Q_W = MANT_W+3 = 26, quotient width and iteration count.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- startDiv  input  1  start request; level-held by the initiator.
- A  input  MANT_W  dividend fraction; sampled in LOAD.
- B  input  MANT_W  divisor fraction; sampled in LOAD.
- quotient  output  Q_W  floor(X*2^(Q_W-1)/Y), where X={1,A} and Y={1,B}.
- sticky  output  1  1 when the final remainder is nonzero.
- doneDiv  output  1  high in IDLE; combinational from state.

Behaviour:
- Reset values: state IDLE, doneDiv=1, quotient=0, sticky=0, remainder reg=0, divisor reg=0, counter=0.
- Registers: R is a MANT_W+2 bit remainder, D is a MANT_W+1 bit divisor, Q is a Q_W bit quotient shift register, cnt is $clog2(Q_W) bits.
- IDLE: doneDiv=1. Go to INIT when startDiv=1, else stay.
- INIT: cnt<=0, Q<=0. Stay while startDiv=1; go to LOAD when startDiv=0.
- LOAD: R<={0,1,A}, D<={1,B}. Go to DIV.
- DIV, once per cycle:
  - diff = R - {0,D}.
  - If diff is non-negative (R>=D): q=1 and R<=diff<<1.
  - Otherwise: q=0 and R<=R<<1.
  - Q<={Q[Q_W-2:0],q}; cnt<=cnt+1.
  - After the cycle with cnt==Q_W-1, go to IDLE.
- Latency: exactly Q_W (26) DIV cycles. doneDiv rises 27 clocks after the first edge that sees startDiv=0 in INIT (1 LOAD + 26 DIV).
- Outputs: quotient=Q and sticky=(R!=0) are continuously driven. They are valid and stable whenever doneDiv=1 after a completed operation, and hold until the next LOAD.
- Width invariant: R<2*D always holds, so MANT_W+2 bits never overflows. Quotient is in [2^(Q_W-2), 2^Q_W).
  - quotient[Q_W-1]=1 means the ratio is >=1; the caller shifts right by 1 and increments the exponent.
  - Otherwise quotient[Q_W-2] is the leading 1.
- Divide-by-zero cannot occur because of the hidden bit. Zero, denormal and special operands are the caller's responsibility.
- startDiv asserted during LOAD or DIV is ignored; the operation completes. A new request is only accepted in IDLE.
- startDiv held high for N cycles stays in INIT; the operation starts only on deassertion.
- A or B changing after LOAD does not affect the result.
- rst mid-operation returns to IDLE immediately, clears all registers, and raises doneDiv asynchronously.

Decomposition:
- Package fp_div_pkg holds:
  - MANT_W default, Q_W and CNT_W constants.
  - State typedef {IDLE, INIT, LOAD, DIV}, 2 bits.
- One natural sub-module, fp_mant_div_dp: datapath holding R, D, Q, the subtractor/compare and the sticky reduction.
  - Control inputs: loadOps, shiftQ, initQ.
  - Top module holds the FSM and counter.

Test Plan:
- Equal operands: A=0, B=0 (1.0/1.0) -> after 27 clocks doneDiv=1, quotient=26'h2000000, sticky=0.
- Quotient >= 1: A=23'h400000, B=0 (1.5/1.0) -> quotient=26'h3000000, sticky=0.
- Inexact result: A=0, B=23'h400000 (1.0/1.5) -> quotient=26'h1555555, sticky=1.
- Extremes:
  - A=23'h7FFFFF, B=0 -> quotient=26'h3FFFFFC, sticky=0.
  - A=0, B=23'h7FFFFF -> quotient=26'h1000001, sticky=1.
- Handshake: hold startDiv for 5 cycles -> FSM stays in INIT and doneDiv=0 throughout. Change A and B during DIV -> result is unchanged from the LOAD-sampled values. Pulse startDiv during DIV -> no restart.
- Reset mid-operation: assert rst at DIV cycle 10 -> doneDiv=1, quotient=0, sticky=0 immediately. A following 1.5/1.0 run -> 26'h3000000.
